// File: rtl/fetch_queue.sv
// Instruction buffer between fetch_b and decode: a small circular FIFO of
// {pc, instr, exc} entries whose oldest entry is presented to decode.
//
// Ports:
//   clk, rst_n     clock and synchronous active-low reset
//   clk_en         global clock enable; state changes only when 1 (reset excepted)
//   flush          discard all entries (redirect)
//   bubble_in      fetch_b output is a bubble (nothing to capture)
//   pc_in          pc of incoming instruction
//   instr_in       instruction word returned by memory
//   exc_in         exception code from fetch_b (0 = none)
//   stall          decode cannot accept an instruction this cycle
//   bubble_out     no valid instruction presented to decode
//   pc_out         pc of head entry (0 when empty)
//   instr_out      instruction of head entry (0 when empty)
//   exc_out        exception code of head entry (0 when empty)
//   fetch_stall    request to hold fetch_a/fetch_b
//   count_out      current occupancy
//   overflow_err   sticky: a push was attempted while full

module fetch_queue #(
    parameter int DEPTH       = 4,
    parameter int STALL_SLACK = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clk_en,
    input  logic                       flush,
    input  logic                       bubble_in,
    input  logic [31:0]                pc_in,
    input  logic [31:0]                instr_in,
    input  logic [7:0]                 exc_in,
    input  logic                       stall,
    output logic                       bubble_out,
    output logic [31:0]                pc_out,
    output logic [31:0]                instr_out,
    output logic [7:0]                 exc_out,
    output logic                       fetch_stall,
    output logic [$clog2(DEPTH):0]     count_out,
    output logic                       overflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    // free <= slack  <=>  count >= DEPTH - slack; a slack of DEPTH or more
    // means fetch is held permanently.
    localparam logic [CW-1:0] STALL_TH =
        (STALL_SLACK >= DEPTH) ? '0 : CW'(DEPTH - STALL_SLACK);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [7:0]  exc;
    } entry_t;

    entry_t          mem_q [DEPTH];

    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;

    logic            empty;
    logic            full;
    logic            push_req;
    logic            pop;
    logic            push_ok;
    entry_t          wr_entry;
    entry_t          head;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_C);

    assign push_req = clk_en && !flush && !bubble_in;
    assign pop      = clk_en && !flush && !stall && !empty;

    // A push into a full queue is only legal when the head leaves
    // on the same edge.
    assign push_ok  = push_req && (!full || pop);

    assign wr_entry = '{pc: pc_in, instr: instr_in, exc: exc_in};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end

            unique case (1'b1)
                (push_ok && !pop): count_d = count_q + CW'(1);
                (!push_ok && pop): count_d = count_q - CW'(1);
                default:           count_d = count_q;
            endcase

            if (push_req && !push_ok) begin
                ovf_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else if (clk_en) begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entry storage carries no reset; stale contents are masked by count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: combinational from head entry and occupancy
    // ------------------------------------------------------------------
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        pc_out    = '0;
        instr_out = '0;
        exc_out   = '0;
        if (!empty) begin
            pc_out    = head.pc;
            instr_out = head.instr;
            exc_out   = head.exc;
        end
    end

    assign bubble_out   = empty;
    assign count_out    = count_q;
    assign fetch_stall  = (count_q >= STALL_TH);
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table, directed corner
// sequences, and randomized traffic against a queue-based reference model.

module tb_fetch_queue;

    localparam int DEPTH       = 4;
    localparam int STALL_SLACK = 2;
    localparam int CW          = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          clk_en;
    logic          flush;
    logic          bubble_in;
    logic [31:0]   pc_in;
    logic [31:0]   instr_in;
    logic [7:0]    exc_in;
    logic          stall;
    logic          bubble_out;
    logic [31:0]   pc_out;
    logic [31:0]   instr_out;
    logic [7:0]    exc_out;
    logic          fetch_stall;
    logic [CW-1:0] count_out;
    logic          overflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_queue #(
        .DEPTH       (DEPTH),
        .STALL_SLACK (STALL_SLACK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_en       (clk_en),
        .flush        (flush),
        .bubble_in    (bubble_in),
        .pc_in        (pc_in),
        .instr_in     (instr_in),
        .exc_in       (exc_in),
        .stall        (stall),
        .bubble_out   (bubble_out),
        .pc_out       (pc_out),
        .instr_out    (instr_out),
        .exc_out      (exc_out),
        .fetch_stall  (fetch_stall),
        .count_out    (count_out),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return ~pc ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic eb,
                           input logic [31:0] epc, input logic [31:0] ein,
                           input logic [7:0] eexc, input logic efs,
                           input int ecnt, input logic eovf);
        chk({tag, ".bubble"}, 64'(bubble_out), 64'(eb));
        chk({tag, ".pc"}, 64'(pc_out), 64'(epc));
        chk({tag, ".instr"}, 64'(instr_out), 64'(ein));
        chk({tag, ".exc"}, 64'(exc_out), 64'(eexc));
        chk({tag, ".fstall"}, 64'(fetch_stall), 64'(efs));
        chk({tag, ".count"}, 64'(count_out), 64'(ecnt));
        chk({tag, ".ovf"}, 64'(overflow_err), 64'(eovf));
    endtask

    // Expected outputs for a queue holding n entries with head pc hp.
    task automatic chk_q(input string tag, input int n,
                         input logic [31:0] hp, input logic [7:0] hexc,
                         input logic eovf);
        logic e;
        e = (n == 0);
        chk_out(tag, e, e ? 32'h0 : hp, e ? 32'h0 : instr_of(hp),
                e ? 8'h0 : hexc, (DEPTH - n) <= STALL_SLACK, n, eovf);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic fl, input logic bub,
                         input logic [31:0] pc, input logic [7:0] exc,
                         input logic st);
        clk_en    = en;
        flush     = fl;
        bubble_in = bub;
        pc_in     = pc;
        instr_in  = instr_of(pc);
        exc_in    = exc;
        stall     = st;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 32'h0, 8'h0, 1'b0);
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        en;
        logic        fl;
        logic        bub;
        logic [31:0] pc;
        logic        st;
        int          ecnt;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[$];

    // Reference model state for randomized traffic.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [7:0]  exc;
    } ent_t;

    ent_t        mq[$];
    logic        movf;

    initial begin
        drive(1'b1, 1'b0, 1'b1, 32'h0, 8'h0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_q("reset", 0, 32'h0, 8'h0, 1'b0);

        // {en, flush, bubble, pc, stall, exp count, exp head pc}
        vecs = '{
            '{1, 0, 1, 32'h000, 0, 0, 32'h000},
            '{1, 0, 0, 32'h400, 0, 1, 32'h400},
            '{1, 0, 0, 32'h404, 0, 1, 32'h404},
            '{1, 0, 0, 32'h408, 0, 1, 32'h408},
            '{1, 0, 1, 32'h000, 0, 0, 32'h000},
            '{1, 0, 0, 32'h400, 1, 1, 32'h400},
            '{1, 0, 0, 32'h404, 1, 2, 32'h400},
            '{1, 0, 0, 32'h408, 1, 3, 32'h400},
            '{1, 0, 0, 32'h40C, 1, 4, 32'h400},
            '{1, 0, 1, 32'h000, 0, 3, 32'h404},
            '{1, 0, 1, 32'h000, 0, 2, 32'h408},
            '{1, 0, 1, 32'h000, 0, 1, 32'h40C},
            '{1, 0, 1, 32'h000, 0, 0, 32'h000},
            '{1, 0, 0, 32'h500, 1, 1, 32'h500},
            '{1, 0, 0, 32'h504, 1, 2, 32'h500},
            '{1, 0, 0, 32'h508, 1, 3, 32'h500},
            '{1, 1, 0, 32'h50C, 0, 0, 32'h000},
            '{1, 0, 0, 32'h600, 1, 1, 32'h600},
            '{0, 0, 0, 32'h604, 0, 1, 32'h600},
            '{1, 0, 1, 32'h000, 0, 0, 32'h000}
        };
        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].fl, vecs[i].bub, vecs[i].pc, 8'h0,
                  vecs[i].st);
            step();
            chk_q($sformatf("vec%0d", i), vecs[i].ecnt, vecs[i].epc, 8'h0,
                  1'b0);
        end

        // Overflow: fill, push once more while stalled, then drain.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h400 + 32'(4 * i), 8'h0, 1'b1);
            step();
        end
        chk_q("ovf.full", 4, 32'h400, 8'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h500, 8'h0, 1'b1);
        step();
        chk_q("ovf.push", 4, 32'h400, 8'h0, 1'b1);
        // Push and pop together while full is legal.
        drive(1'b1, 1'b0, 1'b0, 32'h600, 8'h0, 1'b0);
        step();
        chk_q("ovf.pp", 4, 32'h404, 8'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, 32'h0, 8'h0, 1'b0);
            step();
            chk_q($sformatf("ovf.drain%0d", i), 3 - i,
                  (i < 2) ? 32'h408 + 32'(4 * i) : 32'h600, 8'h0, 1'b1);
        end
        // Reset mid-operation with entries present.
        drive(1'b1, 1'b0, 1'b0, 32'h700, 8'h0, 1'b1);
        step();
        do_reset();
        chk_q("ovf.reset", 0, 32'h0, 8'h0, 1'b0);

        // Exception carried with entry; clk_en low holds everything.
        drive(1'b1, 1'b0, 1'b0, 32'h402, 8'h84, 1'b1);
        step();
        chk_q("exc.push", 1, 32'h402, 8'h84, 1'b0);
        // Bubble with exception is not pushed.
        drive(1'b1, 1'b0, 1'b1, 32'h999, 8'h22, 1'b1);
        step();
        chk_q("exc.bub", 1, 32'h402, 8'h84, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h800, 8'h0, 1'b0);
            step();
            chk_q($sformatf("clken%0d", i), 1, 32'h402, 8'h84, 1'b0);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h800, 8'h0, 1'b0);
        step();
        chk_q("clken.flush", 1, 32'h402, 8'h84, 1'b0);

        // Wrap: 10 push/pop pairs keep one entry and advance both pointers.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h1000 + 32'(4 * i), 8'(i), 1'b0);
            step();
            chk_q($sformatf("wrap%0d", i), 1, 32'h1000 + 32'(4 * i), 8'(i),
                  1'b0);
        end
        drive(1'b1, 1'b0, 1'b1, 32'h0, 8'h0, 1'b0);
        step();
        chk_q("wrap.end", 0, 32'h0, 8'h0, 1'b0);

        // Randomized traffic against a queue model.
        do_reset();
        mq.delete();
        movf = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic        r_rst;
            logic        pop_m;
            ent_t        e;
            r_rst     = ($urandom_range(99) < 1);
            rst_n     = !r_rst;
            clk_en    = ($urandom_range(99) < 85);
            flush     = ($urandom_range(99) < 4);
            bubble_in = ($urandom_range(99) < 35);
            stall     = ($urandom_range(99) < 45);
            pc_in     = $urandom;
            instr_in  = $urandom;
            exc_in    = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h0;

            if (r_rst) begin
                mq.delete();
                movf = 1'b0;
            end else if (clk_en) begin
                if (flush) begin
                    mq.delete();
                end else begin
                    pop_m = !stall && (mq.size() > 0);
                    if (!bubble_in && !pop_m && mq.size() == DEPTH) begin
                        movf = 1'b1;
                    end else begin
                        if (pop_m) void'(mq.pop_front());
                        if (!bubble_in) begin
                            e.pc    = pc_in;
                            e.instr = instr_in;
                            e.exc   = exc_in;
                            mq.push_back(e);
                        end
                    end
                end
            end
            step();
            if (mq.size() == 0) begin
                chk_out($sformatf("rnd%0d", c), 1'b1, 32'h0, 32'h0, 8'h0,
                        (DEPTH <= STALL_SLACK), 0, movf);
            end else begin
                chk_out($sformatf("rnd%0d", c), 1'b0, mq[0].pc,
                        mq[0].instr, mq[0].exc,
                        (DEPTH - mq.size()) <= STALL_SLACK, mq.size(),
                        movf);
            end
        end
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between fetch_b and decode.
- Captures each non-bubble fetch result (pc, instruction word, exception code) into a small circular FIFO and presents the oldest entry to decode.
- Decouples fetch from decode stalls. Asserts fetch_stall early enough to absorb the two fetches already in flight in the 2-cycle memory pipe.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 4.
- STALL_SLACK, 2, fetch_stall asserts when free entries <= STALL_SLACK (in-flight fetches).

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- clk_en  input  1  global clock enable; state changes only when 1 (reset excepted).
- flush  input  1  discard all entries (branch / interrupt / rfe redirect).
- bubble_in  input  1  fetch_b output is a bubble.
- pc_in  input  32  pc of incoming instruction.
- instr_in  input  32  instruction word returned by memory.
- exc_in  input  8  exception code from fetch_b (0 = none).
- stall  input  1  decode cannot accept an instruction this cycle.
- bubble_out  output  1  no valid instruction presented to decode.
- pc_out  output  32  pc of head entry.
- instr_out  output  32  instruction of head entry.
- exc_out  output  8  exception code of head entry.
- fetch_stall  output  1  request to hold fetch_a/fetch_b.
- count_out  output  $clog2(DEPTH)+1  current occupancy.
- overflow_err  output  1  sticky: a push was attempted while full.

Behaviour:
- Storage:
  - DEPTH entries of {pc 32, instr 32, exc 8}.
  - rd_ptr and wr_ptr are $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count is $clog2(DEPTH)+1 bits.
- Reset (rst_n=0 at posedge, regardless of clk_en):
  - rd_ptr=0, wr_ptr=0, count=0, overflow_err=0.
  - Outputs: bubble_out=1, pc_out=0, instr_out=0, exc_out=0, fetch_stall=0, count_out=0.
  - Entry contents are don't-care.
  - Reset mid-operation discards all entries.
- push = clk_en && !flush && !bubble_in.
- pop = clk_en && !flush && !stall && (count != 0).
- Outputs are combinational from head entry and count; no extra register stage:
  - bubble_out = (count == 0).
  - pc_out, instr_out, exc_out = entry[rd_ptr] when count != 0.
  - pc_out, instr_out, exc_out are forced to 0 when empty.
- Latency: an entry pushed at edge N is visible on outputs after edge N. There is no same-cycle bypass from inputs to outputs.
- Per-edge update when clk_en=1:
  - flush: rd_ptr=wr_ptr=0, count=0. Overrides push and pop; the incoming instruction is dropped. overflow_err is unchanged.
  - push only: write at wr_ptr, wr_ptr+1, count+1.
  - pop only: rd_ptr+1, count-1.
  - push and pop together: both pointers advance; count unchanged. Legal when full or with count=1.
  - push while full and no pop: write suppressed, pointers and count unchanged, overflow_err set to 1 (sticky until reset).
- clk_en=0: all state held; outputs remain stable.
- fetch_stall = (DEPTH - count) <= STALL_SLACK.
  - Combinational from count, so fetch sees it the same cycle occupancy crosses the threshold.
  - The in-flight fetches then fit without overflow.
- Exceptions:
  - Nonzero exc_in is stored with its entry and delivered in order.
  - The queue does not act on exception codes.
  - A bubble with nonzero exc_in is not pushed; fetch_b guarantees exceptions travel on non-bubbles.
- Count never exceeds DEPTH. Pointer wrap from DEPTH-1 to 0 is seamless.

Test Plan:
- Reset then idle: rst_n=0 one edge, bubble_in=1 -> bubble_out=1, count_out=0, fetch_stall=0, overflow_err=0.
- Stream with stall=0: push pc 0x400, 0x404, 0x408 on consecutive cycles -> outputs show each pc one cycle after its push; count_out stays 1; order preserved.
- Back-pressure, DEPTH=4: stall=1, push 0x400 and 0x404 -> count_out=2, fetch_stall=1. Push 0x408 and 0x40C -> count_out=4, no overflow. Release stall -> outputs 0x400, 0x404, 0x408, 0x40C on 4 consecutive cycles.
- Flush priority: count=3, flush=1 with push and pop also requested -> next cycle count_out=0, bubble_out=1. Incoming instr absent. Next push appears normally.
- Overflow: full with stall=1, push 0x500 -> count_out=4, head still 0x400, overflow_err=1. It stays 1 after draining; cleared only by rst_n=0.
- Exception and clk_en:
  - Push pc 0x402 with exc_in=0x84 -> exc_out=0x84 at head.
  - Hold clk_en=0 for 3 cycles with stall=0 -> outputs and count unchanged.
  - Wrap: 10 push/pop pairs -> pointers wrap, data intact.
